jk_seq_detector: RTL and testbench

//  Serial pattern detector that consumes the single-bit Q stream of the JK flip-flop stage.

---
 rtl/jk_seq_detector_if.sv | 22 ++
 rtl/jk_seq_detector.sv | 90 +++++++++
 tb/tb_jk_seq_detector.sv | 249 ++++++++++++++++++++++++
 3 files changed

// File: rtl/jk_seq_detector_if.sv
// Bundle between the JK flip-flop stage (master: Q stream) and the pattern detector (slave).
interface jk_seq_detector_if #(
  parameter int CNT_WIDTH = 8,
  parameter int STATE_W   = 2
);
  logic                 din;
  logic                 valid;
  logic                 detect;
  logic [CNT_WIDTH-1:0] count;
  logic                 sat;
  logic [STATE_W-1:0]   state;

  modport master (
    output din, valid,
    input  detect, count, sat, state
  );

  modport slave (
    input  din, valid,
    output detect, count, sat, state
  );
endinterface

// File: rtl/jk_seq_detector.sv
// Serial pattern detector on the JK stage Q stream: KMP-style match-length FSM, one-cycle
// registered detect pulse, saturating match counter. Never back-pressures its source.
module jk_seq_detector #(
  parameter int                     PATTERN_LEN = 4,
  parameter logic [PATTERN_LEN-1:0] PATTERN     = 4'b1011,
  parameter bit                     OVERLAP     = 1'b1,
  parameter int                     CNT_WIDTH   = 8
) (
  input logic               clk_i,
  input logic               rst_i,
  jk_seq_detector_if.slave  bus
);

  localparam int SW = $clog2(PATTERN_LEN);

  typedef logic [SW-1:0] state_t;

  // Longest pattern prefix that is a suffix of (top k pattern bits, then b), capped below
  // PATTERN_LEN so a full match folds back to its longest proper border.
  function automatic int next_len(input int k, input logic b);
    int   best;
    int   p;
    logic ok;
    logic s_bit;
    best = 0;
    if (!(k == PATTERN_LEN - 1 && b == PATTERN[0] && !OVERLAP)) begin
      for (int l = PATTERN_LEN - 1; l >= 1; l--) begin
        if (best == 0 && l <= k + 1) begin
          ok = 1'b1;
          for (int j = 0; j < l; j++) begin
            p     = k + 1 - l + j;
            s_bit = (p == k) ? b : PATTERN[PATTERN_LEN-1-p];
            if (s_bit != PATTERN[PATTERN_LEN-1-j]) ok = 1'b0;
          end
          if (ok) best = l;
        end
      end
    end
    return best;
  endfunction

  state_t nxt_tbl [PATTERN_LEN][2];

  for (genvar k = 0; k < PATTERN_LEN; k++) begin : g_tbl
    assign nxt_tbl[k][0] = SW'(next_len(k, 1'b0));
    assign nxt_tbl[k][1] = SW'(next_len(k, 1'b1));
  end

  state_t               state_q, state_d;
  logic                 detect_q, detect_d;
  logic [CNT_WIDTH-1:0] count_q, count_d;
  logic                 sat_q, sat_d;
  logic                 full_match;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= '0;
      detect_q <= 1'b0;
      count_q  <= '0;
      sat_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      detect_q <= detect_d;
      count_q  <= count_d;
      sat_q    <= sat_d;
    end
  end

  assign full_match = (state_q == SW'(PATTERN_LEN - 1)) && (bus.din == PATTERN[0]);

  always_comb begin
    state_d  = state_q;
    detect_d = 1'b0;
    count_d  = count_q;
    if (bus.valid) begin
      state_d = nxt_tbl[state_q][bus.din];
      if (full_match) begin
        detect_d = 1'b1;
        if (!sat_q) count_d = count_q + CNT_WIDTH'(1);
      end
    end
    sat_d = &count_d;
  end

  assign bus.detect = detect_q;
  assign bus.count  = count_q;
  assign bus.sat    = sat_q;
  assign bus.state  = state_q;

endmodule

// File: tb/tb_jk_seq_detector.sv
// Directed bench for jk_seq_detector: overlapping, non-overlapping and saturating instances share one stimulus stream.
module tb_jk_seq_detector;

  logic clk;
  logic rst;
  logic din;
  logic valid;
  int   n_checks;
  int   n_fail;

  jk_seq_detector_if #(.CNT_WIDTH(8), .STATE_W(2)) if_ov  ();
  jk_seq_detector_if #(.CNT_WIDTH(8), .STATE_W(2)) if_no  ();
  jk_seq_detector_if #(.CNT_WIDTH(2), .STATE_W(2)) if_sat ();

  assign if_ov.din    = din;
  assign if_ov.valid  = valid;
  assign if_no.din    = din;
  assign if_no.valid  = valid;
  assign if_sat.din   = din;
  assign if_sat.valid = valid;

  jk_seq_detector #(.OVERLAP(1'b1), .CNT_WIDTH(8)) u_ov (
    .clk_i (clk), .rst_i (rst), .bus (if_ov.slave)
  );
  jk_seq_detector #(.OVERLAP(1'b0), .CNT_WIDTH(8)) u_no (
    .clk_i (clk), .rst_i (rst), .bus (if_no.slave)
  );
  jk_seq_detector #(.OVERLAP(1'b1), .CNT_WIDTH(2)) u_sat (
    .clk_i (clk), .rst_i (rst), .bus (if_sat.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Apply one bit, then settle 1 time unit past the edge before anyone samples.
  task automatic step(input logic d, input logic v);
    din   = d;
    valid = v;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step(1'b1, 1'b1);
    step(1'b1, 1'b1);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    step(1'b1, 1'b1);
    step(1'b0, 1'b1);
    rst = 1'b0;
    n_checks++;
    if (if_ov.detect !== 1'b0 || if_ov.count !== 8'd0 || if_ov.sat !== 1'b0 || if_ov.state !== 2'd0) begin
      n_fail++;
      $display("FAIL reset_ov: det=%b cnt=%0d sat=%b st=%0d, expected all zero",
               if_ov.detect, if_ov.count, if_ov.sat, if_ov.state);
    end
    n_checks++;
    if (if_no.detect !== 1'b0 || if_no.count !== 8'd0 || if_no.sat !== 1'b0 || if_no.state !== 2'd0) begin
      n_fail++;
      $display("FAIL reset_no: det=%b cnt=%0d sat=%b st=%0d, expected all zero",
               if_no.detect, if_no.count, if_no.sat, if_no.state);
    end
    n_checks++;
    if (if_sat.detect !== 1'b0 || if_sat.count !== 2'd0 || if_sat.sat !== 1'b0 || if_sat.state !== 2'd0) begin
      n_fail++;
      $display("FAIL reset_sat: det=%b cnt=%0d sat=%b st=%0d, expected all zero",
               if_sat.detect, if_sat.count, if_sat.sat, if_sat.state);
    end
  endtask

  // Stream 1,0,1,1,0,1,1: border of 1011 is "1", so the second match reuses the last bit.
  task automatic test_overlap();
    logic [6:0] bits;
    logic [6:0] det;
    int         st [7];
    bits = 7'b1011011;
    det  = 7'b0001001;
    st   = '{1, 2, 3, 1, 2, 3, 1};
    do_reset();
    for (int i = 0; i < 7; i++) begin
      step(bits[6-i], 1'b1);
      n_checks++;
      if (if_ov.state !== 2'(st[i]) || if_ov.detect !== det[6-i]) begin
        n_fail++;
        $display("FAIL overlap_bit%0d: st=%0d det=%b, expected st=%0d det=%b",
                 i + 1, if_ov.state, if_ov.detect, st[i], det[6-i]);
      end
    end
    n_checks++;
    if (if_ov.count !== 8'd2) begin
      n_fail++;
      $display("FAIL overlap_count: got %0d expected 2", if_ov.count);
    end
  endtask

  // Same stream without overlap: restart at 0 after the match, later "11" falls back to 1.
  task automatic test_no_overlap();
    logic [6:0] bits;
    logic [6:0] det;
    int         st [7];
    bits = 7'b1011011;
    det  = 7'b0001000;
    st   = '{1, 2, 3, 0, 0, 1, 1};
    do_reset();
    for (int i = 0; i < 7; i++) begin
      step(bits[6-i], 1'b1);
      n_checks++;
      if (if_no.state !== 2'(st[i]) || if_no.detect !== det[6-i]) begin
        n_fail++;
        $display("FAIL no_overlap_bit%0d: st=%0d det=%b, expected st=%0d det=%b",
                 i + 1, if_no.state, if_no.detect, st[i], det[6-i]);
      end
    end
    n_checks++;
    if (if_no.count !== 8'd1) begin
      n_fail++;
      $display("FAIL no_overlap_count: got %0d expected 1", if_no.count);
    end
  endtask

  // 1,0,1,0: "1010" ends in "10", so the mismatch lands in state 2.
  task automatic test_fallback();
    logic [5:0] bits;
    logic [5:0] det;
    int         st [6];
    bits = 6'b101011;
    det  = 6'b000001;
    st   = '{1, 2, 3, 2, 3, 1};
    do_reset();
    for (int i = 0; i < 6; i++) begin
      step(bits[5-i], 1'b1);
      n_checks++;
      if (if_ov.state !== 2'(st[i]) || if_ov.detect !== det[5-i]) begin
        n_fail++;
        $display("FAIL fallback_bit%0d: st=%0d det=%b, expected st=%0d det=%b",
                 i + 1, if_ov.state, if_ov.detect, st[i], det[5-i]);
      end
    end
    n_checks++;
    if (if_ov.count !== 8'd1) begin
      n_fail++;
      $display("FAIL fallback_count: got %0d expected 1", if_ov.count);
    end
  endtask

  // Valid gaps freeze the match; a trailing idle cycle clears detect but keeps count.
  task automatic test_valid_gap();
    logic [7:0] d_v;
    logic [7:0] v_v;
    logic [7:0] det;
    int         st [8];
    int         cnt [8];
    d_v = 8'b10101011;
    v_v = 8'b11100010;
    det = 8'b00000010;
    st  = '{1, 2, 3, 3, 3, 3, 1, 1};
    cnt = '{0, 0, 0, 0, 0, 0, 1, 1};
    do_reset();
    for (int i = 0; i < 8; i++) begin
      step(d_v[7-i], v_v[7-i]);
      n_checks++;
      if (if_ov.state !== 2'(st[i]) || if_ov.detect !== det[7-i] || if_ov.count !== 8'(cnt[i])) begin
        n_fail++;
        $display("FAIL gap_cyc%0d: st=%0d det=%b cnt=%0d, expected st=%0d det=%b cnt=%0d",
                 i + 1, if_ov.state, if_ov.detect, if_ov.count, st[i], det[7-i], cnt[i]);
      end
    end
  endtask

  // Five overlapping matches on a 2-bit counter: holds at 3, detect keeps pulsing.
  task automatic test_saturate();
    logic [2:0] tail;
    int         exp_cnt;
    tail = 3'b011;
    do_reset();
    step(1'b1, 1'b1);
    step(1'b0, 1'b1);
    step(1'b1, 1'b1);
    for (int m = 1; m <= 5; m++) begin
      if (m > 1) begin
        step(tail[2], 1'b1);
        n_checks++;
        if (if_sat.detect !== 1'b0) begin
          n_fail++;
          $display("FAIL sat_nodet_m%0d: det=%b expected 0", m, if_sat.detect);
        end
        step(tail[1], 1'b1);
      end
      step(tail[0], 1'b1);
      exp_cnt = (m > 3) ? 3 : m;
      n_checks++;
      if (if_sat.detect !== 1'b1 || if_sat.count !== 2'(exp_cnt) || if_sat.sat !== (m >= 3)) begin
        n_fail++;
        $display("FAIL sat_match%0d: det=%b cnt=%0d sat=%b, expected det=1 cnt=%0d sat=%b",
                 m, if_sat.detect, if_sat.count, if_sat.sat, exp_cnt, (m >= 3));
      end
    end
  endtask

  // Reset wins over a valid matching bit and discards the partial match.
  task automatic test_reset_mid();
    step(1'b1, 1'b1);
    step(1'b0, 1'b1);
    step(1'b1, 1'b1);
    n_checks++;
    if (if_sat.state !== 2'd3) begin
      n_fail++;
      $display("FAIL mid_prefix: st=%0d expected 3", if_sat.state);
    end
    rst = 1'b1;
    step(1'b1, 1'b1);
    rst = 1'b0;
    n_checks++;
    if (if_sat.state !== 2'd0 || if_sat.count !== 2'd0 || if_sat.sat !== 1'b0 || if_sat.detect !== 1'b0) begin
      n_fail++;
      $display("FAIL mid_reset: st=%0d cnt=%0d sat=%b det=%b, expected all zero",
               if_sat.state, if_sat.count, if_sat.sat, if_sat.detect);
    end
    step(1'b1, 1'b1);
    n_checks++;
    if (if_sat.state !== 2'd1 || if_sat.detect !== 1'b0 || if_sat.count !== 2'd0) begin
      n_fail++;
      $display("FAIL mid_after: st=%0d det=%b cnt=%0d, expected st=1 det=0 cnt=0",
               if_sat.state, if_sat.detect, if_sat.count);
    end
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    rst      = 1'b1;
    din      = 1'b0;
    valid    = 1'b0;
    test_reset();
    test_overlap();
    test_no_overlap();
    test_fallback();
    test_valid_gap();
    test_saturate();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
